// File: rtl/obstacle_manager.sv
// obstacle_manager: ring-allocated obstacle slots with scroll, spawn, AABB collision and sprite-ROM addressing.
// Define OBSTACLE_HITBOX_INSET_EN to shrink obstacle collision boxes by INSET px on every side.
module obstacle_manager #(
    parameter int N_SLOTS     = 3,
    parameter int X_W         = 13,
    parameter int SCREEN_W    = 640,
    parameter int GROUND_Y    = 350,
    parameter int MIN_GAP     = 250,
    parameter int GAP_MASK    = 511,
    parameter int BASE_SPEED  = 4,
    parameter int SPEED_SHIFT = 4,
    parameter int MAX_SPEED   = 12,
    parameter int IMG_W       = 481,
    parameter int ROM_LAT     = 1,
    parameter int T0_W        = 38,
    parameter int T0_H        = 30,
    parameter int T0_SX       = 90,
    parameter int T1_W        = 39,
    parameter int T1_H        = 40,
    parameter int T1_SX       = 141,
    parameter int T2_W        = 36,
    parameter int T2_H        = 34,
    parameter int T2_SX       = 52,
    parameter int T2_ALT      = 40,
    parameter int INSET       = 4
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               run,
    input  logic               clear,
    input  logic [9:0]         rand_in,
    input  logic [9:0]         score,
    input  logic [9:0]         player_x,
    input  logic [9:0]         player_y,
    input  logic [5:0]         player_w,
    input  logic [5:0]         player_h,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    output logic [N_SLOTS-1:0] active,
    output logic               collision,
    output logic [16:0]        sprite_addr,
    output logic               obs_hit
);
    localparam int IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CW = X_W + 2;
`ifdef OBSTACLE_HITBOX_INSET_EN
    localparam bit INSET_EN = 1'b1;
`else
    localparam bit INSET_EN = 1'b0;
`endif
    localparam int HB = INSET_EN ? INSET : 0;

    function automatic logic signed [CW-1:0] obs_w(input logic [1:0] t);
        return CW'(t == 2'd2 ? T2_W : t == 2'd1 ? T1_W : T0_W);
    endfunction

    function automatic logic signed [CW-1:0] obs_h(input logic [1:0] t);
        return CW'(t == 2'd2 ? T2_H : t == 2'd1 ? T1_H : T0_H);
    endfunction

    function automatic logic signed [CW-1:0] obs_top(input logic [1:0] t);
        return CW'(t == 2'd2 ? GROUND_Y - T2_ALT - T2_H : t == 2'd1 ? GROUND_Y - T1_H : GROUND_Y - T0_H);
    endfunction

    // The pterodactyl flaps by flipping to the neighbouring frame 19 px to the right.
    function automatic logic [16:0] obs_sx(input logic [1:0] t, input logic alt);
        return 17'(t == 2'd2 ? T2_SX + (alt ? 19 : 0) : t == 2'd1 ? T1_SX : T0_SX);
    endfunction

    logic signed [X_W-1:0] x_q [N_SLOTS];
    logic signed [X_W-1:0] x_d [N_SLOTS];
    logic [1:0]            type_q [N_SLOTS];
    logic [1:0]            type_d [N_SLOTS];
    logic [N_SLOTS-1:0]    active_q, active_d;
    logic [IW-1:0]         last_idx_q, last_idx_d, target, sel;
    logic                  spawn_pending_q, spawn_pending_d;
    logic [9:0]            gap_q, gap_d;
    logic [4:0]            frame_cnt_q, frame_cnt_d;
    logic                  collision_q, collision_d;
    logic [16:0]           sprite_addr_q, sprite_addr_d;
    logic [ROM_LAT:0]      hit_sr_q, hit_sr_d;
    logic [10:0]           spd_raw;
    logic [X_W-1:0]        speed;
    logic signed [CW-1:0]  thr, dx, dy;
    logic signed [CW-1:0]  px, py, pw, ph, hc, vc;
    logic                  spawn, overlap, pix_hit;
    logic [1:0]            new_type;

    assign px = CW'($signed({1'b0, player_x}));
    assign py = CW'($signed({1'b0, player_y}));
    assign pw = CW'($signed({1'b0, player_w}));
    assign ph = CW'($signed({1'b0, player_h}));
    assign hc = CW'($signed({1'b0, h_cnt}));
    assign vc = CW'($signed({1'b0, v_cnt}));

    always_comb begin
        spd_raw = 11'(BASE_SPEED) + 11'(score >> SPEED_SHIFT);
        speed = (spd_raw > 11'(MAX_SPEED)) ? X_W'(MAX_SPEED) : X_W'(spd_raw);
        target = (last_idx_q == IW'(N_SLOTS - 1)) ? '0 : last_idx_q + 1'b1;
        thr = CW'(SCREEN_W - MIN_GAP) - CW'($signed({1'b0, gap_q}));
        // Spawn spacing is judged on positions before this tick's move.
        spawn = frame_tick && run && !active_q[target] && (spawn_pending_q || CW'(x_q[last_idx_q]) < thr);
        new_type = (rand_in[9:8] == 2'd3) ? 2'd0 : rand_in[9:8];
        x_d = x_q;
        type_d = type_q;
        active_d = active_q;
        last_idx_d = last_idx_q;
        spawn_pending_d = spawn_pending_q;
        gap_d = gap_q;
        frame_cnt_d = frame_cnt_q + 5'(frame_tick);
        if (frame_tick && run)
            for (int i = 0; i < N_SLOTS; i++)
                if (active_q[i]) begin
                    x_d[i] = x_q[i] - $signed(speed);
                    if (CW'(x_d[i]) + obs_w(type_q[i]) <= 0)
                        active_d[i] = 1'b0;
                end
        if (spawn) begin
            x_d[target] = X_W'(SCREEN_W);
            type_d[target] = new_type;
            active_d[target] = 1'b1;
            last_idx_d = target;
            gap_d = rand_in & 10'(GAP_MASK);
            spawn_pending_d = 1'b0;
        end
        if (clear) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                x_d[i] = X_W'(SCREEN_W);
                type_d[i] = 2'd0;
            end
            active_d = '0;
            last_idx_d = IW'(N_SLOTS - 1);
            spawn_pending_d = 1'b1;
            gap_d = '0;
            frame_cnt_d = '0;
        end
    end

    always_comb begin
        overlap = 1'b0;
        for (int i = 0; i < N_SLOTS; i++)
            if (active_q[i]
                && px < CW'(x_q[i]) + obs_w(type_q[i]) - CW'(HB)
                && CW'(x_q[i]) + CW'(HB) < px + pw
                && py < obs_top(type_q[i]) + obs_h(type_q[i]) - CW'(HB)
                && obs_top(type_q[i]) + CW'(HB) < py + ph)
                overlap = 1'b1;
        collision_d = !clear && (collision_q || overlap);
    end

    // Descending scan leaves the lowest-index containing slot selected.
    always_comb begin
        pix_hit = 1'b0;
        sel = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--)
            if (active_q[i] && hc >= CW'(x_q[i]) && hc < CW'(x_q[i]) + obs_w(type_q[i])
                && vc >= obs_top(type_q[i]) && vc < obs_top(type_q[i]) + obs_h(type_q[i])) begin
                pix_hit = 1'b1;
                sel = IW'(i);
            end
        dx = hc - CW'(x_q[sel]);
        dy = vc - obs_top(type_q[sel]);
        sprite_addr_d = (pix_hit && !clear)
            ? 17'(dy[CW-1:1]) * 17'(IMG_W) + obs_sx(type_q[sel], frame_cnt_q[4]) + 17'(dx[CW-1:1]) : '0;
        hit_sr_d = clear ? '0 : {hit_sr_q[ROM_LAT-1:0], pix_hit};
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                x_q[i]    <= X_W'(SCREEN_W);
                type_q[i] <= 2'd0;
            end
            active_q        <= '0;
            last_idx_q      <= IW'(N_SLOTS - 1);
            spawn_pending_q <= 1'b1;
            gap_q           <= '0;
            frame_cnt_q     <= '0;
            collision_q     <= 1'b0;
            sprite_addr_q   <= '0;
            hit_sr_q        <= '0;
        end else begin
            x_q             <= x_d;
            type_q          <= type_d;
            active_q        <= active_d;
            last_idx_q      <= last_idx_d;
            spawn_pending_q <= spawn_pending_d;
            gap_q           <= gap_d;
            frame_cnt_q     <= frame_cnt_d;
            collision_q     <= collision_d;
            sprite_addr_q   <= sprite_addr_d;
            hit_sr_q        <= hit_sr_d;
        end
    end

    assign active      = active_q;
    assign collision   = collision_q;
    assign sprite_addr = sprite_addr_q;
    assign obs_hit     = hit_sr_q[ROM_LAT];
endmodule

// File: tb/tb_obstacle_manager.sv
// tb_obstacle_manager: directed checks of spawn, scroll, speed, types, collision and sprite addressing.
module tb_obstacle_manager;
    logic        pclk = 1'b0, rst = 1'b1, frame_tick = 1'b0, run = 1'b0, clear = 1'b0;
    logic [9:0]  rand_in = '0, score = '0, player_x = '0, player_y = '0, h_cnt = '0, v_cnt = '0;
    logic [5:0]  player_w = 6'd1, player_h = 6'd1;
    logic [2:0]  active;
    logic [1:0]  active2;
    logic        collision, collision2, obs_hit, obs_hit2;
    logic [16:0] sprite_addr, sprite_addr2;
    int          total = 0, bad = 0;
`ifdef OBSTACLE_HITBOX_INSET_EN
    localparam logic EXP_COL_190 = 1'b0;
`else
    localparam logic EXP_COL_190 = 1'b1;
`endif

    always #5 pclk = ~pclk;

    obstacle_manager u_dut (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .run(run), .clear(clear),
        .rand_in(rand_in), .score(score), .player_x(player_x), .player_y(player_y),
        .player_w(player_w), .player_h(player_h), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .active(active), .collision(collision), .sprite_addr(sprite_addr), .obs_hit(obs_hit)
    );

    obstacle_manager #(.N_SLOTS(2)) u_dut2 (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .run(run), .clear(clear),
        .rand_in(rand_in), .score(score), .player_x(player_x), .player_y(player_y),
        .player_w(player_w), .player_h(player_h), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .active(active2), .collision(collision2), .sprite_addr(sprite_addr2), .obs_hit(obs_hit2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic [16:0] exp, input string tag);
        h_cnt = h;
        v_cnt = v;
        step();
        chk(tag, sprite_addr, exp);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_active", active, 0);
        chk("rst_col", collision, 0);
        chk("rst_addr", sprite_addr, 0);
        chk("rst_obs_hit", obs_hit, 0);
        rst = 1'b0;
        run = 1'b1;
        do_clear();
        tick();
        chk("spawn0_mask", active, 3'b001);
        chk("spawn0_mask_n2", active2, 2'b01);
        probe(640, 320, 90, "x640_addr");
        chk("x640_obs_hit_early", obs_hit, 0);
        step();
        chk("x640_obs_hit", obs_hit, 1);
        probe(639, 320, 0, "x639_miss");
        tick();
        probe(636, 320, 90, "x636_addr");
        probe(638, 322, 572, "x636_off_addr");
        repeat (62) tick();
        chk("t64_mask", active, 3'b001);
        tick();
        chk("t65_mask", active, 3'b011);
        chk("t65_mask_n2", active2, 2'b11);
        repeat (63) tick();
        chk("t128_mask", active, 3'b011);
        tick();
        chk("t129_mask", active, 3'b111);
        repeat (41) tick();
        chk("t170_mask_n2", active2, 2'b11);
        tick();
        chk("t171_mask_n2", active2, 2'b10);
        chk("t171_mask", active, 3'b110);
        tick();
        chk("t172_mask_n2", active2, 2'b11);
        chk("t172_mask", active, 3'b110);
        do_clear();
        score = 10'd64;
        tick();
        tick();
        probe(632, 320, 90, "spd8_addr");
        probe(631, 320, 0, "spd8_edge");
        score = 10'd512;
        tick();
        probe(620, 320, 90, "spd12_addr");
        probe(619, 320, 0, "spd12_edge");
        run = 1'b0;
        tick();
        tick();
        probe(620, 320, 90, "frozen_addr");
        chk("frozen_mask", active, 3'b001);
        run = 1'b1;
        do_clear();
        rand_in = 10'd256;
        tick();
        probe(640, 310, 141, "t1_addr");
        probe(640, 349, 9280, "t1_bottom_addr");
        probe(640, 350, 0, "t1_below");
        do_clear();
        rand_in = 10'd768;
        tick();
        probe(640, 320, 90, "t3_as_t0_addr");
        probe(640, 310, 0, "t3_as_t0_top");
        do_clear();
        rand_in = 10'd512;
        tick();
        probe(640, 276, 52, "t2_addr");
        repeat (15) tick();
        probe(460, 276, 71, "t2_alt_addr");
        do_clear();
        rand_in = 10'd0;
        score = 10'd16;
        h_cnt = 10'd0;
        v_cnt = 10'd0;
        player_x = 10'd160;
        player_y = 10'd314;
        player_w = 6'd34;
        player_h = 6'd36;
        tick();
        repeat (88) tick();
        probe(210, 330, 2500, "px_addr");
        chk("px_addr_n2", sprite_addr2, 2500);
        chk("px_obs_hit_early", obs_hit, 0);
        step();
        chk("px_obs_hit", obs_hit, 1);
        chk("px_obs_hit_n2", obs_hit2, 1);
        h_cnt = 10'd0;
        v_cnt = 10'd0;
        tick();
        step();
        chk("col_x195", collision, 0);
        tick();
        chk("col_same_cycle", collision, 0);
        step();
        chk("col_x190", collision, EXP_COL_190);
        repeat (14) tick();
        chk("col_sticky", collision, 1);
        chk("col_sticky_n2", collision2, 1);
        do_clear();
        chk("clear_col", collision, 0);
        chk("clear_mask", active, 0);
        player_x = 10'd0;
        player_y = 10'd0;
        player_w = 6'd1;
        player_h = 6'd1;
        tick();
        chk("respawn_mask", active, 3'b001);
        clear = 1'b1;
        frame_tick = 1'b1;
        step();
        clear = 1'b0;
        frame_tick = 1'b0;
        chk("clr_tick_mask", active, 0);
        tick();
        probe(640, 320, 90, "clr_tick_respawn");
        step();
        chk("pre_arst_obs_hit", obs_hit, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_addr", sprite_addr, 0);
        chk("arst_obs_hit", obs_hit, 0);
        chk("arst_mask", active, 0);
        step();
        rst = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
